// File: rtl/mesh_term_fifo_bank.sv
// rtl/mesh_term_fifo_bank.sv - per-terminal FWFT injection FIFO bank with status, sticky flags and hold
module mesh_term_fifo_bank #(
  parameter int ROWS    = 4,
  parameter int COLUMS  = 4,
  parameter int PCKG_SZ = 40,
  parameter int DEPTH   = 8,
  parameter int AF_LVL  = 6,
  localparam int N_TERM = ROWS*2 + COLUMS*2,
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_TERM-1:0]         push_i,
  input  logic [N_TERM*PCKG_SZ-1:0] push_data_i,
  input  logic [N_TERM-1:0]         hold_i,
  input  logic                      clr_flags_i,
  input  logic [N_TERM-1:0]         popin_i,
  output logic [N_TERM-1:0]         pndng_o,
  output logic [N_TERM*PCKG_SZ-1:0] data_o,
  output logic [N_TERM-1:0]         full_o,
  output logic [N_TERM-1:0]         afull_o,
  output logic [N_TERM*CNT_W-1:0]   count_o,
  output logic [N_TERM-1:0]         ovf_o,
  output logic [N_TERM-1:0]         udf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);

  for (genvar k = 0; k < N_TERM; k++) begin : g_ch
    logic [PCKG_SZ-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               udf;
    logic               full;
    logic               pndng;
    logic               pop_eff;
    logic               push_ok;

    // Status decode from registered occupancy; hold only masks the head toward the router
    assign full    = (cnt == DEPTH_C);
    assign pndng   = (cnt != '0) && !hold_i[k];
    assign pop_eff = popin_i[k] && pndng;
    assign push_ok = push_i[k] && (!full || pop_eff);

    // Storage write; contents survive reset, only pointers are cleared
    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data_i[k*PCKG_SZ +: PCKG_SZ];
      end
    end

    // Pointer, occupancy and sticky flag update; a set event beats a clear in the same cycle
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_eff) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        unique case ({push_ok, pop_eff})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        ovf <= (push_i[k] && full && !pop_eff) || (ovf && !clr_flags_i);
        udf <= (popin_i[k] && !pndng) || (udf && !clr_flags_i);
      end
    end

    // Channel outputs; data is forced to zero whenever the head is not offered
    always_comb begin
      pndng_o[k]                   = pndng;
      data_o[k*PCKG_SZ +: PCKG_SZ] = pndng ? mem[rd_ptr] : '0;
      full_o[k]                    = full;
      afull_o[k]                   = (cnt >= AF_C);
      count_o[k*CNT_W +: CNT_W]    = cnt;
      ovf_o[k]                     = ovf;
      udf_o[k]                     = udf;
    end
  end

endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// tb/tb_mesh_term_fifo_bank.sv - scoreboard bench for mesh_term_fifo_bank
module tb_mesh_term_fifo_bank;

  localparam int N  = 16;
  localparam int W  = 40;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   push_i;
  logic [N*W-1:0] push_data_i;
  logic [N-1:0]   hold_i;
  logic           clr_flags_i;
  logic [N-1:0]   popin_i;
  logic [N-1:0]   pndng_o;
  logic [N*W-1:0] data_o;
  logic [N-1:0]   full_o;
  logic [N-1:0]   afull_o;
  logic [N*CW-1:0] count_o;
  logic [N-1:0]   ovf_o;
  logic [N-1:0]   udf_o;

  int total = 0;
  int bad   = 0;

  mesh_term_fifo_bank #(.ROWS(4), .COLUMS(4), .PCKG_SZ(W), .DEPTH(D), .AF_LVL(AF)) dut (
    .clk(clk), .reset(reset), .push_i(push_i), .push_data_i(push_data_i),
    .hold_i(hold_i), .clr_flags_i(clr_flags_i), .popin_i(popin_i),
    .pndng_o(pndng_o), .data_o(data_o), .full_o(full_o), .afull_o(afull_o),
    .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk = ~clk;

  // reference model: one queue of expected words per terminal plus sticky flags
  logic [W-1:0] mq [N][$];
  logic [N-1:0] m_ovf;
  logic [N-1:0] m_udf;
  bit           mvalid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dat(input int k);
    return data_o[k*W +: W];
  endfunction

  function automatic logic [CW-1:0] cnt(input int k);
    return count_o[k*CW +: CW];
  endfunction

  // model update on each edge from the stimulus applied to that edge
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      int  sz;
      bit  pnd, pop, ovf_ev, udf_ev;
      if (reset) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
        m_udf[k] = 1'b0;
      end else begin
        sz     = mq[k].size();
        pnd    = (sz != 0) && !hold_i[k];
        pop    = popin_i[k] && pnd;
        ovf_ev = push_i[k] && (sz == D) && !pop;
        udf_ev = popin_i[k] && !pnd;
        if (pop) void'(mq[k].pop_front());
        if (push_i[k] && !ovf_ev) mq[k].push_back(push_data_i[k*W +: W]);
        m_ovf[k] = ovf_ev || (m_ovf[k] && !clr_flags_i);
        m_udf[k] = udf_ev || (m_udf[k] && !clr_flags_i);
      end
    end
    if (reset) mvalid = 1'b1;
  end

  // monitor: compare every channel's presented outputs against the model mid-cycle
  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < N; k++) begin
        int sz;
        bit ep;
        sz = mq[k].size();
        ep = (sz != 0) && !hold_i[k];
        chk($sformatf("mon_pndng[%0d]", k), 64'(pndng_o[k]), 64'(ep));
        chk($sformatf("mon_data[%0d]", k), 64'(dat(k)), ep ? 64'(mq[k][0]) : 64'd0);
        chk($sformatf("mon_count[%0d]", k), 64'(cnt(k)), 64'(sz));
        chk($sformatf("mon_full[%0d]", k), 64'(full_o[k]), 64'(sz == D));
        chk($sformatf("mon_afull[%0d]", k), 64'(afull_o[k]), 64'(sz >= AF));
        chk($sformatf("mon_ovf[%0d]", k), 64'(ovf_o[k]), 64'(m_ovf[k]));
        chk($sformatf("mon_udf[%0d]", k), 64'(udf_o[k]), 64'(m_udf[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    push_i      = '0;
    popin_i     = '0;
    clr_flags_i = 1'b0;
  endtask

  task automatic junk();
    push_i      = N'($urandom);
    hold_i      = N'($urandom);
    popin_i     = N'($urandom);
    clr_flags_i = 1'($urandom);
    for (int i = 0; i < N*W/32; i++) push_data_i[i*32 +: 32] = $urandom;
  endtask

  task automatic push_ch(input int k, input logic [W-1:0] v);
    push_i[k]          = 1'b1;
    push_data_i[k*W +: W] = v;
  endtask

  initial begin
    reset       = 1'b1;
    push_data_i = '0;
    hold_i      = '0;
    push_i      = '0;
    popin_i     = '0;
    clr_flags_i = 1'b0;

    // reset with junk on every input
    junk();
    tick();
    junk();
    tick();
    hold_i = '0;
    #1;
    chk("rst_pndng", 64'(pndng_o), 64'd0);
    chk("rst_data", 64'(|data_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_afull", 64'(afull_o), 64'd0);
    chk("rst_count", 64'(|count_o), 64'd0);
    chk("rst_flags", 64'(ovf_o | udf_o), 64'd0);
    reset = 1'b0;
    tick();

    // fill then drain channel 0
    for (int i = 1; i <= 8; i++) begin
      push_ch(0, W'(i));
      tick();
      chk($sformatf("fill_afull_%0d", i), 64'(afull_o[0]), 64'(i >= 6));
      chk($sformatf("fill_full_%0d", i), 64'(full_o[0]), 64'(i == 8));
      chk($sformatf("fill_count_%0d", i), 64'(cnt(0)), 64'(i));
    end
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_data_%0d", i), 64'(dat(0)), 64'(i));
      popin_i[0] = 1'b1;
      tick();
    end
    chk("drain_pndng", 64'(pndng_o[0]), 64'd0);

    // overflow on channel 3, then full push+pop
    for (int i = 0; i < 8; i++) begin
      push_ch(3, W'(32'h300 + i));
      tick();
    end
    push_ch(3, W'(8'hAA));
    tick();
    chk("ovf_flag", 64'(ovf_o[3]), 64'd1);
    chk("ovf_count", 64'(cnt(3)), 64'd8);
    push_ch(3, W'(8'h77));
    popin_i[3] = 1'b1;
    tick();
    chk("fullpp_count", 64'(cnt(3)), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain_%0d", i), 64'(dat(3)), (i < 7) ? 64'(32'h301 + i) : 64'h77);
      popin_i[3] = 1'b1;
      tick();
    end
    popin_i[3] = 1'b1;
    tick();
    chk("ovf_udf", 64'(udf_o[3]), 64'd1);
    clr_flags_i = 1'b1;
    tick();
    chk("clr_flags", 64'(ovf_o[3] | udf_o[3]), 64'd0);

    // hold and underflow on channel 5
    push_ch(5, W'(8'h5A));
    hold_i[5] = 1'b1;
    tick();
    chk("hold_pndng", 64'(pndng_o[5]), 64'd0);
    chk("hold_data", 64'(dat(5)), 64'd0);
    popin_i[5] = 1'b1;
    tick();
    chk("hold_udf", 64'(udf_o[5]), 64'd1);
    chk("hold_count", 64'(cnt(5)), 64'd1);
    hold_i[5] = 1'b0;
    #1;
    chk("release_pndng", 64'(pndng_o[5]), 64'd1);
    chk("release_data", 64'(dat(5)), 64'h5A);
    popin_i[5] = 1'b1;
    tick();

    // random push/pop/hold on channel 15
    for (int c = 0; c < 100; c++) begin
      if ($urandom_range(0, 1) == 1) push_ch(15, {8'($urandom), $urandom});
      popin_i[15] = ($urandom_range(0, 2) == 0);
      hold_i[15]  = ($urandom_range(0, 7) == 0);
      clr_flags_i = ($urandom_range(0, 15) == 0);
      tick();
    end
    hold_i = '0;

    // mid-traffic reset on channel 2
    for (int i = 0; i < 5; i++) begin
      push_ch(2, W'(32'h200 + i));
      tick();
    end
    chk("mid_count5", 64'(cnt(2)), 64'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_count0", 64'(cnt(2)), 64'd0);
    chk("mid_pndng0", 64'(pndng_o[2]), 64'd0);
    push_ch(2, W'(8'h55));
    tick();
    chk("mid_first", 64'(dat(2)), 64'h55);
    chk("mid_pndng1", 64'(pndng_o[2]), 64'd1);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
